// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array sequencer.
// Sequence lengths are given both as functions of N and as defaults for N = 3.
package systolic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    DONE
  } ctrl_state_t;

  localparam int DEFAULT_MATRIX_SIZE = 3;

  // Skewed operand streaming spans 2N-1 steps; N more steps drain the diagonal.
  function automatic int feed_cycles(input int n);
    return 2 * n - 1;
  endfunction

  function automatic int drain_cycles(input int n);
    return n;
  endfunction

  localparam int FEED_CYCLES  = feed_cycles(DEFAULT_MATRIX_SIZE);
  localparam int DRAIN_CYCLES = drain_cycles(DEFAULT_MATRIX_SIZE);

  localparam logic BANK_A = 1'b0;
  localparam logic BANK_B = 1'b1;

endpackage

// File: rtl/operand_bank.sv
// N x N operand register file: one write port, N combinational read ports.
// Port p reads row p (READ_BY_ROW = 1) or column p (READ_BY_ROW = 0) at rd_idx[p].
module operand_bank #(
  parameter int N           = 3,
  parameter int DW          = 8,
  parameter bit READ_BY_ROW = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          we,
  input  logic [$clog2(N)-1:0]          wr_row,
  input  logic [$clog2(N)-1:0]          wr_col,
  input  logic [DW-1:0]                 wr_data,
  input  logic [N*$clog2(N)-1:0]        rd_idx,
  output logic [N*DW-1:0]               rd_data
);

  localparam int IW = $clog2(N);

  logic [DW-1:0] mem [N][N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          mem[r][c] <= '0;
        end
      end
    end else if (we) begin
      mem[wr_row][wr_col] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int p = 0; p < N; p++) begin
      if (READ_BY_ROW) begin
        rd_data[p*DW +: DW] = mem[p][rd_idx[p*IW +: IW]];
      end else begin
        rd_data[p*DW +: DW] = mem[rd_idx[p*IW +: IW]][p];
      end
    end
  end

endmodule

// File: rtl/systolic_ctrl.sv
// Sequencer for an output-stationary systolic array: clears the array, streams
// skewed A rows / B columns, drains the pipeline and pulses done.
module systolic_ctrl
  import systolic_pkg::*;
#(
  parameter int MATRIX_SIZE = 3,
  parameter int DATA_WIDTH  = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              wr_en,
  input  logic                              wr_sel,
  input  logic [$clog2(MATRIX_SIZE)-1:0]    wr_row,
  input  logic [$clog2(MATRIX_SIZE)-1:0]    wr_col,
  input  logic [DATA_WIDTH-1:0]             wr_data,
  input  logic                              start,
  output logic                              busy,
  output logic                              done,
  output logic                              wr_err,
  output logic                              arr_rst,
  output logic                              arr_en,
  output logic [MATRIX_SIZE*DATA_WIDTH-1:0] arr_left,
  output logic [MATRIX_SIZE*DATA_WIDTH-1:0] arr_top
);

  localparam int N         = MATRIX_SIZE;
  localparam int DW        = DATA_WIDTH;
  localparam int IW        = $clog2(N);
  localparam int SW        = $clog2(2 * N);
  localparam int FEED_LEN  = feed_cycles(N);
  localparam int DRAIN_LEN = drain_cycles(N);

  ctrl_state_t   state, state_next;
  logic [SW-1:0] step, step_next;

  logic [N*IW-1:0] skew_idx;
  logic [N-1:0]    lane_ok;
  logic [N*DW-1:0] a_rd, b_rd;
  logic [N*DW-1:0] left_next, top_next;
  logic            feeding;
  logic            idle_wr;

  assign idle_wr = wr_en && (state == IDLE);

  operand_bank #(.N(N), .DW(DW), .READ_BY_ROW(1'b1)) u_bank_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (idle_wr && (wr_sel == BANK_A)),
    .wr_row  (wr_row),
    .wr_col  (wr_col),
    .wr_data (wr_data),
    .rd_idx  (skew_idx),
    .rd_data (a_rd)
  );

  operand_bank #(.N(N), .DW(DW), .READ_BY_ROW(1'b0)) u_bank_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (idle_wr && (wr_sel == BANK_B)),
    .wr_row  (wr_row),
    .wr_col  (wr_col),
    .wr_data (wr_data),
    .rd_idx  (skew_idx),
    .rd_data (b_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      step  <= '0;
    end else begin
      state <= state_next;
      step  <= step_next;
    end
  end

  always_comb begin
    state_next = state;
    step_next  = step;
    case (state)
      IDLE:  if (start) state_next = CLEAR;
      CLEAR: begin
        state_next = FEED;
        step_next  = '0;
      end
      FEED: begin
        if (step == SW'(FEED_LEN - 1)) begin
          state_next = DRAIN;
          step_next  = '0;
        end else begin
          step_next = step + 1'b1;
        end
      end
      DRAIN: begin
        if (step == SW'(DRAIN_LEN - 1)) begin
          state_next = DONE;
          step_next  = '0;
        end else begin
          step_next = step + 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state, so the skew is computed for
  // step_next; lane k carries element (t - k) of its row/column when in range.
  always_comb begin
    int d;
    d        = 0;
    skew_idx = '0;
    lane_ok  = '0;
    for (int k = 0; k < N; k++) begin
      d = int'(step_next) - k;
      if (d >= 0 && d < N) begin
        lane_ok[k]           = 1'b1;
        skew_idx[k*IW +: IW] = IW'(d);
      end
    end
  end

  assign feeding = (state_next == FEED);

  always_comb begin
    left_next = '0;
    top_next  = '0;
    for (int k = 0; k < N; k++) begin
      if (feeding && lane_ok[k]) begin
        left_next[k*DW +: DW] = a_rd[k*DW +: DW];
        top_next[k*DW +: DW]  = b_rd[k*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      wr_err   <= 1'b0;
      arr_rst  <= 1'b1;
      arr_en   <= 1'b0;
      arr_left <= '0;
      arr_top  <= '0;
    end else begin
      busy     <= (state_next != IDLE);
      done     <= (state_next == DONE);
      wr_err   <= wr_en && (state != IDLE);
      arr_rst  <= (state_next == CLEAR);
      arr_en   <= (state_next == FEED) || (state_next == DRAIN);
      arr_left <= left_next;
      arr_top  <= top_next;
    end
  end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench for systolic_ctrl: timeline model of the sequencer, a behavioural
// output-stationary array driven by the DUT feeds, and literal C expectations.
module tb_systolic_ctrl;

  localparam int N  = 3;
  localparam int DW = 8;
  localparam int IW = 2;
  localparam int CW = 32;
  localparam int EW = N * N * CW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wr_en = 1'b0;
  logic wr_sel = 1'b0;
  logic [IW-1:0] wr_row = '0;
  logic [IW-1:0] wr_col = '0;
  logic [DW-1:0] wr_data = '0;
  logic start = 1'b0;
  logic busy, done, wr_err, arr_rst, arr_en;
  logic [N*DW-1:0] arr_left, arr_top;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  logic [EW-1:0] exp_q[$];
  int cv[9];

  systolic_ctrl #(.MATRIX_SIZE(N), .DATA_WIDTH(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_sel   (wr_sel),
    .wr_row   (wr_row),
    .wr_col   (wr_col),
    .wr_data  (wr_data),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .wr_err   (wr_err),
    .arr_rst  (arr_rst),
    .arr_en   (arr_en),
    .arr_left (arr_left),
    .arr_top  (arr_top)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- timeline model ----------------
  // rel counts cycles since the accepted start: 1 = clear, 2..2N = feed,
  // 2N+1..3N = drain, 3N+1 = done.
  logic [DW-1:0] ma[N][N];
  logic [DW-1:0] mb[N][N];
  bit running = 1'b0;
  int rel = 0;
  bit in_rst = 1'b1;
  bit exp_wr_err = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running    <= 1'b0;
      rel        <= 0;
      in_rst     <= 1'b1;
      exp_wr_err <= 1'b0;
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) begin
          ma[r][c] <= '0;
          mb[r][c] <= '0;
        end
    end else begin
      in_rst     <= 1'b0;
      exp_wr_err <= wr_en && running;
      if (running) begin
        if (rel == 3 * N + 1) begin
          running <= 1'b0;
          rel     <= 0;
        end else begin
          rel <= rel + 1;
        end
      end else begin
        if (wr_en && !wr_sel) ma[wr_row][wr_col] <= wr_data;
        if (wr_en && wr_sel)  mb[wr_row][wr_col] <= wr_data;
        if (start) begin
          running <= 1'b1;
          rel     <= 1;
        end
      end
    end
  end

  function automatic logic [N*DW-1:0] exp_left();
    logic [N*DW-1:0] v;
    int t;
    v = '0;
    t = rel - 2;
    if (running && rel >= 2 && rel <= 2 * N)
      for (int i = 0; i < N; i++)
        if (t - i >= 0 && t - i < N) v[i*DW +: DW] = ma[i][t-i];
    return v;
  endfunction

  function automatic logic [N*DW-1:0] exp_top();
    logic [N*DW-1:0] v;
    int t;
    v = '0;
    t = rel - 2;
    if (running && rel >= 2 && rel <= 2 * N)
      for (int j = 0; j < N; j++)
        if (t - j >= 0 && t - j < N) v[j*DW +: DW] = mb[t-j][j];
    return v;
  endfunction

  // ---------------- behavioural array fed by the DUT ----------------
  logic [DW-1:0] ah[N][N];
  logic [DW-1:0] bv[N][N];
  logic [CW-1:0] acc[N][N];

  function automatic logic [DW-1:0] a_in(input int i, input int j);
    if (j == 0) return arr_left[i*DW +: DW];
    return ah[i][j-1];
  endfunction

  function automatic logic [DW-1:0] b_in(input int i, input int j);
    if (i == 0) return arr_top[j*DW +: DW];
    return bv[i-1][j];
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        if (arr_rst) begin
          ah[i][j]  <= '0;
          bv[i][j]  <= '0;
          acc[i][j] <= '0;
        end else if (arr_en) begin
          ah[i][j]  <= a_in(i, j);
          bv[i][j]  <= b_in(i, j);
          acc[i][j] <= acc[i][j] + CW'(a_in(i, j)) * CW'(b_in(i, j));
        end
      end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [EW-1:0] ev;
    check("busy",     64'(busy),     64'(running));
    check("done",     64'(done),     64'(running && rel == 3 * N + 1));
    check("wr_err",   64'(wr_err),   64'(exp_wr_err));
    check("arr_rst",  64'(arr_rst),  64'(in_rst || (running && rel == 1)));
    check("arr_en",   64'(arr_en),   64'(running && rel >= 2 && rel <= 3 * N));
    check("arr_left", 64'(arr_left), 64'(exp_left()));
    check("arr_top",  64'(arr_top),  64'(exp_top()));
    if (done) begin
      done_cnt++;
      check("done_has_expect", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
        ev = exp_q.pop_front();
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++)
            check($sformatf("c_%0d%0d", i, j), 64'(acc[i][j]), 64'(ev[(i*N+j)*CW +: CW]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [DW-1:0] pat(input int p, input int r, input int c);
    case (p)
      0:       return DW'(r * N + c + 1);
      1:       return DW'(r == c);
      2:       return DW'(9 - (r * N + c));
      3:       return DW'(1);
      default: return DW'(255);
    endcase
  endfunction

  task automatic load_mats(input int pa, input int pb);
    for (int s = 0; s < 2; s++)
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) begin
          @(negedge clk);
          wr_en   = 1'b1;
          wr_sel  = s[0];
          wr_row  = IW'(r);
          wr_col  = IW'(c);
          wr_data = (s == 0) ? pat(pa, r, c) : pat(pb, r, c);
        end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic push_exp();
    logic [EW-1:0] v;
    for (int k = 0; k < 9; k++) v[k*CW +: CW] = CW'(cv[k]);
    exp_q.push_back(v);
  endtask

  // inj: cycle for a mid-run start+write; rst_at: cycle to pulse rst_n;
  // wr_now: write A[0][0]=2 together with start; skew: literal feed checks.
  task automatic run(input int inj, input int rst_at, input bit wr_now, input bit skew, input bit expect_done);
    int lat;
    bit seen;
    @(negedge clk);
    start = 1'b1;
    if (wr_now) begin
      wr_en = 1'b1; wr_sel = 1'b0; wr_row = '0; wr_col = '0; wr_data = 8'd2;
    end
    lat  = 0;
    seen = 1'b0;
    while (lat < 40) begin
      @(negedge clk);
      start = 1'b0;
      wr_en = 1'b0;
      lat++;
      if (inj > 0 && lat == inj) begin
        start = 1'b1; wr_en = 1'b1; wr_sel = 1'b0; wr_row = '0; wr_col = '0; wr_data = 8'd99;
      end
      if (inj > 0 && lat == inj + 1) check("wr_err_pulse", 64'(wr_err), 64'(1));
      if (skew && lat == 2) begin
        check("skew_left_t0", 64'(arr_left), 64'(24'h000001));
        check("skew_top_t0",  64'(arr_top),  64'(24'h000001));
      end
      if (skew && lat == 4) check("skew_left_t2", 64'(arr_left), 64'(24'h010101));
      if (skew && lat == 6) check("skew_top_t4",  64'(arr_top),  64'(24'h010000));
      if (rst_at > 0 && lat == rst_at) begin
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy",    64'(busy),     64'(0));
        check("midrst_arr_en",  64'(arr_en),   64'(0));
        check("midrst_arr_rst", 64'(arr_rst),  64'(1));
        check("midrst_left",    64'(arr_left), 64'(0));
        check("midrst_top",     64'(arr_top),  64'(0));
      end
      if (rst_at > 0 && lat == rst_at + 3) #2 rst_n = 1'b1;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (expect_done) check("done_latency", 64'(lat), 64'(3 * N + 1));
    else             check("no_done", 64'(seen), 64'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (2) @(negedge clk);
    check("reset_arr_rst", 64'(arr_rst), 64'(1));
    check("reset_busy",    64'(busy),    64'(0));
    check("reset_arr_en",  64'(arr_en),  64'(0));
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_arr_rst", 64'(arr_rst), 64'(0));

    // identity product
    load_mats(0, 1);
    cv = '{1, 2, 3, 4, 5, 6, 7, 8, 9}; push_exp();
    run(0, 0, 1'b0, 1'b0, 1'b1);

    // general product, then re-run back-to-back with unchanged banks
    load_mats(0, 2);
    cv = '{30, 24, 18, 84, 69, 54, 138, 114, 90}; push_exp();
    run(0, 0, 1'b0, 1'b0, 1'b1);
    push_exp();
    run(0, 0, 1'b0, 1'b0, 1'b1);

    // skew pattern with all ones
    load_mats(3, 3);
    cv = '{3, 3, 3, 3, 3, 3, 3, 3, 3}; push_exp();
    run(0, 0, 1'b0, 1'b1, 1'b1);

    // max operands
    load_mats(4, 4);
    cv = '{195075, 195075, 195075, 195075, 195075, 195075, 195075, 195075, 195075}; push_exp();
    run(0, 0, 1'b0, 1'b0, 1'b1);

    // busy protection: start and write mid-feed are ignored
    load_mats(0, 2);
    cv = '{30, 24, 18, 84, 69, 54, 138, 114, 90}; push_exp();
    run(3, 0, 1'b0, 1'b0, 1'b1);

    // write in the start cycle is used by the run
    cv = '{39, 32, 25, 84, 69, 54, 138, 114, 90}; push_exp();
    run(0, 0, 1'b1, 1'b0, 1'b1);

    // reset at feed t = 2, then reload and rerun
    run(0, 4, 1'b0, 1'b0, 1'b0);
    load_mats(0, 2);
    cv = '{30, 24, 18, 84, 69, 54, 138, 114, 90}; push_exp();
    run(0, 0, 1'b0, 1'b0, 1'b1);

    repeat (2) @(negedge clk);
    check("done_count",  64'(done_cnt),     64'(8));
    check("exp_q_empty", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/systolic_ctrl.md
# systolic_ctrl

Sequencer for the output-stationary `systolic_array`. Holds one N×N A operand and one N×N B operand in local banks. On `start` it clears the array and streams A rows into `in_left` and B columns into `in_top` with the diagonal skew the array needs. It then drains the pipeline, freezes the array and pulses `done`, so `acc_out` holds C = A·B. It sits between the host/DMA write port and the array instance.

## Interface
- `MATRIX_SIZE`, 3, array dimension N (≥2)
- `DATA_WIDTH`, 8, operand width; must match the array
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `wr_en`  in  1  operand write strobe
- `wr_sel`  in  1  0 = A bank, 1 = B bank
- `wr_row`  in  $clog2(N)  row index
- `wr_col`  in  $clog2(N)  column index
- `wr_data`  in  DATA_WIDTH  operand value
- `start`  in  1  begin a multiply (one-cycle pulse)
- `busy`  out  1  high from the cycle after `start` is accepted until `done`
- `done`  out  1  one-cycle pulse; `acc_out` is valid and frozen
- `wr_err`  out  1  one-cycle pulse when a write is dropped because `busy` is high
- `arr_rst`  out  1  active-high clear for the array `rst` input
- `arr_en`  out  1  array enable
- `arr_left`  out  [N] × DATA_WIDTH  to array `in_left`
- `arr_top`  out  [N] × DATA_WIDTH  to array `in_top`

## Operation
- FSM states: IDLE → CLEAR → FEED → DRAIN → DONE → IDLE.
- **IDLE**
  - `arr_en` = 0; the array holds its last results.
  - Writes are accepted: `bank[wr_sel][wr_row][wr_col] <= wr_data`.
  - `start` moves the FSM to CLEAR.
- **CLEAR** (1 cycle)
  - `arr_rst` = 1, `arr_en` = 0, feeds = 0.
- **FEED** (2N−1 cycles, step counter t = 0..2N−2)
  - `arr_en` = 1.
  - `arr_left[i]` = A[i][t−i] when 0 ≤ t−i < N, else 0.
  - `arr_top[j]` = B[t−j][j] when 0 ≤ t−j < N, else 0.
- **DRAIN** (N cycles)
  - `arr_en` = 1, feeds = 0, so the last operands propagate to PE(N−1,N−1).
- **DONE** (1 cycle)
  - `done` = 1, `arr_en` = 0, then IDLE.
- **Ignored inputs**
  - `start` outside IDLE is ignored.
  - `wr_en` outside IDLE is dropped and pulses `wr_err`.
  - A write and `start` in the same IDLE cycle: the write is committed first, and FEED uses the new value.
- **Width rules**
  - Operands pass through unmodified (unsigned, DATA_WIDTH).
  - The step counter is $clog2(2N) bits and never wraps.
- **Banks**
  - Bank contents persist across runs, so re-running `start` with unchanged banks reproduces C.

## Timing
- All outputs are registered.
- Reset values:
  - `busy`, `done`, `wr_err`, `arr_en` = 0.
  - `arr_rst` = 1 while `rst_n` is low, 0 on the first cycle after release.
  - Feeds = 0.
  - Banks = 0.
  - FSM = IDLE.
- `start` sampled high at edge k gives:
  - `arr_rst` high during k+1.
  - FEED during k+2 .. k+2N.
  - DRAIN during k+2N+1 .. k+3N.
  - `done` high during k+3N+1.
  - `busy` high during k+1 .. k+3N+1, low at k+3N+2.
  - For N=3: `done` appears 10 cycles after `start`.
- A new `start` is accepted the cycle `busy` is low again, giving back-to-back throughput of 3N+2 cycles.
- `rst_n` asserted mid-run:
  - FSM returns to IDLE immediately.
  - Feeds zero and `arr_en` = 0 asynchronously.
  - Banks cleared.
  - No `done`.

## Structure
- Package `systolic_pkg`:
  - state enum `ctrl_state_t` (IDLE, CLEAR, FEED, DRAIN, DONE).
  - localparams `FEED_CYCLES` = 2N−1 and `DRAIN_CYCLES` = N.
  - bank-select constants.
- Sub-module `operand_bank`:
  - N×N register file with one write port and N combinational read ports, indexed by row or column.
  - Instantiated twice: A read by row with skewed column, B read by column with skewed row.
- Top `systolic_ctrl`: FSM, step counter and skew index logic.

## Test plan
- **Identity product:** A = [[1,2,3],[4,5,6],[7,8,9]], B = I, `start` → `done` at +10 cycles, `acc_out` = A.
- **General product:** A as above, B = [[9,8,7],[6,5,4],[3,2,1]] → C = [[30,24,18],[84,69,54],[138,114,90]].
- **Skew check:** A = all 1, B = all 1 → per-cycle `arr_left`/`arr_top` match the skew pattern (row i nonzero only for t = i..i+N−1); C = all 3.
- **Max values:** A = B = all 255 → C = all 195075; no truncation in the array.
- **Busy protection:** `start` and `wr_en` pulsed mid-FEED → no restart, `wr_err` pulses, results equal the pre-write product, a single `done`.
- **Reset mid-run:** `rst_n` low at FEED t = 2 → outputs zero immediately, `done` never asserts; after a reload and `start`, the correct C is produced.
